// File: rtl/sys_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus_responder_if
// Purpose  : sys read/write strobes plus the console TX byte stream.
// Revision : 1.0  initial release
// ============================================================================
interface sys_bus_responder_if;
  logic [31:0] sys_r_addr;
  logic        sys_r;
  logic [31:0] sys_r_line;
  logic [31:0] sys_w_addr;
  logic        sys_w;
  logic [31:0] sys_w_line;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  sys_r_addr, sys_r, sys_w_addr, sys_w, sys_w_line, tx_ready,
    output sys_r_line, tx_data, tx_valid
  );

  modport master (
    output sys_r_addr, sys_r, sys_w_addr, sys_w, sys_w_line, tx_ready,
    input  sys_r_line, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/sys_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus_responder
// Purpose  : sys-space register block: ID, scratch, cycle counter, timer, TX FIFO.
// Revision : 1.0  initial release
// ============================================================================
module sys_bus_responder #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          FIFO_AW = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sys_bus_responder_if.slave bus,
  output logic               irq
);

  localparam logic [3:0] OFF_ID      = 4'd0;
  localparam logic [3:0] OFF_SCRATCH = 4'd1;
  localparam logic [3:0] OFF_CYCLE   = 4'd2;
  localparam logic [3:0] OFF_TCNT    = 4'd3;
  localparam logic [3:0] OFF_TRELOAD = 4'd4;
  localparam logic [3:0] OFF_TCTRL   = 4'd5;
  localparam logic [3:0] OFF_TSTAT   = 4'd6;
  localparam logic [3:0] OFF_TXDATA  = 4'd7;
  localparam logic [3:0] OFF_TXSTAT  = 4'd8;
  localparam logic [31:0] C_ID       = 32'hC0DE_0032;
  localparam logic [31:0] C_UNMAPPED = 32'hAAAA_AAAA;
  localparam int          DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);

  logic [31:0]        r_scratch, r_cycle, r_tmr_cnt, r_tmr_reload;
  logic               r_en, r_auto, r_ie, r_exp, r_ovf;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_level;

  logic        w_full, w_empty, w_pop, w_push_req, w_push, w_drop;
  logic        w_we, w_hw_exp, w_en_clr;
  logic [31:0] w_tx_stat, w_tmr_cnt_nxt;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_tx_stat = {21'b0, r_ovf, w_empty, w_full, 8'b0} | 32'(r_level);

  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign irq          = r_exp & r_ie;

  // Read path is purely combinational on pre-edge state.
  always_comb begin
    bus.sys_r_line = '0;
    if (bus.sys_r) begin
      if (bus.sys_r_addr[31:4] != BASE[31:4]) begin
        bus.sys_r_line = C_UNMAPPED;
      end else begin
        case (bus.sys_r_addr[3:0])
          OFF_ID:      bus.sys_r_line = C_ID;
          OFF_SCRATCH: bus.sys_r_line = r_scratch;
          OFF_CYCLE:   bus.sys_r_line = r_cycle;
          OFF_TCNT:    bus.sys_r_line = r_tmr_cnt;
          OFF_TRELOAD: bus.sys_r_line = r_tmr_reload;
          OFF_TCTRL:   bus.sys_r_line = {29'b0, r_ie, r_auto, r_en};
          OFF_TSTAT:   bus.sys_r_line = {31'b0, r_exp};
          OFF_TXDATA:  bus.sys_r_line = '0;
          OFF_TXSTAT:  bus.sys_r_line = w_tx_stat;
          default:     bus.sys_r_line = C_UNMAPPED;
        endcase
      end
    end
  end

  assign w_we       = bus.sys_w && (bus.sys_w_addr[31:4] == BASE[31:4]);
  assign w_pop      = !w_empty && bus.tx_ready;
  assign w_push_req = w_we && (bus.sys_w_addr[3:0] == OFF_TXDATA);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  always_comb begin
    w_tmr_cnt_nxt = r_tmr_cnt;
    w_hw_exp      = 1'b0;
    w_en_clr      = 1'b0;
    if (r_en) begin
      if (r_tmr_cnt != 32'd0) begin
        w_tmr_cnt_nxt = r_tmr_cnt - 32'd1;
      end else begin
        w_hw_exp = 1'b1;
        if (r_auto) w_tmr_cnt_nxt = r_tmr_reload;
        else        w_en_clr      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scratch    <= '0;
      r_cycle      <= '0;
      r_tmr_cnt    <= '0;
      r_tmr_reload <= '0;
      r_en         <= 1'b0;
      r_auto       <= 1'b0;
      r_ie         <= 1'b0;
      r_exp        <= 1'b0;
      r_ovf        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      r_tmr_cnt <= w_tmr_cnt_nxt;
      if (w_en_clr) r_en <= 1'b0;
      // Hardware set of a sticky flag overrides a same-cycle W1C.
      r_exp <= (r_exp & ~(w_we && bus.sys_w_addr[3:0] == OFF_TSTAT && bus.sys_w_line[0]))
               | w_hw_exp;
      r_ovf <= (r_ovf & ~(w_we && bus.sys_w_addr[3:0] == OFF_TXSTAT && bus.sys_w_line[10]))
               | w_drop;
      if (w_we) begin
        case (bus.sys_w_addr[3:0])
          OFF_SCRATCH: r_scratch    <= bus.sys_w_line;
          OFF_CYCLE:   r_cycle      <= bus.sys_w_line;
          OFF_TCNT:    r_tmr_cnt    <= bus.sys_w_line;
          OFF_TRELOAD: r_tmr_reload <= bus.sys_w_line;
          OFF_TCTRL:   {r_ie, r_auto, r_en} <= bus.sys_w_line[2:0];
          default: ;
        endcase
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (!w_push && w_pop) r_level <= r_level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr] <= bus.sys_w_line[7:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_bus_responder
// Purpose  : table, directed and random checks against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sys_bus_responder;
  localparam logic [31:0] BASE    = 32'h0001_0040;
  localparam int          FIFO_AW = 3;
  localparam int          DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;
  logic ready_v = 1'b0;

  sys_bus_responder_if bus();

  sys_bus_responder #(.BASE(BASE), .FIFO_AW(FIFO_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_scratch, m_cycle, m_cnt, m_reload;
  bit          m_en, m_auto, m_ie, m_exp, m_ovf;
  logic [7:0]  m_q[$];

  typedef struct {
    logic        r;
    logic [31:0] addr;
    logic [31:0] exp;
  } rvec_t;
  rvec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic m_reset();
    m_scratch = 0; m_cycle = 0; m_cnt = 0; m_reload = 0;
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ovf = 0;
    m_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    if (a[31:4] != BASE[31:4]) return 32'hAAAA_AAAA;
    case (a[3:0])
      4'd0: v = 32'hC0DE_0032;
      4'd1: v = m_scratch;
      4'd2: v = m_cycle;
      4'd3: v = m_cnt;
      4'd4: v = m_reload;
      4'd5: v = {29'b0, m_ie, m_auto, m_en};
      4'd6: v = {31'b0, m_exp};
      4'd7: v = 32'h0;
      4'd8: v = 32'(m_q.size()) | ((m_q.size() == DEPTH) ? 32'h100 : 32'h0)
                | ((m_q.size() == 0) ? 32'h200 : 32'h0) | (m_ovf ? 32'h400 : 32'h0);
      default: v = 32'hAAAA_AAAA;
    endcase
    return v;
  endfunction

  // One clock edge of the specified behaviour, from the inputs seen before it.
  task automatic m_step(input bit rr, input bit w, input logic [31:0] wa,
                        input logic [31:0] wd, input bit rdy);
    bit          mapped, pop, push, full0, en_n;
    logic [31:0] cnt_n;
    if (!rr) begin
      m_reset();
      return;
    end
    mapped = w && (wa[31:4] == BASE[31:4]);
    full0  = (m_q.size() == DEPTH);
    pop    = (m_q.size() > 0) && rdy;
    push   = mapped && (wa[3:0] == 4'd7);
    cnt_n  = m_cnt;
    en_n   = m_en;
    m_cycle = m_cycle + 1;
    if (mapped) begin
      case (wa[3:0])
        4'd6: if (wd[0]) m_exp = 0;
        4'd8: if (wd[10]) m_ovf = 0;
        default: ;
      endcase
    end
    if (m_en) begin
      if (m_cnt == 0) begin
        m_exp = 1;
        if (m_auto) cnt_n = m_reload;
        else        en_n  = 0;
      end else begin
        cnt_n = m_cnt - 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full0 || pop) m_q.push_back(wd[7:0]);
      else               m_ovf = 1;
    end
    if (mapped) begin
      case (wa[3:0])
        4'd1: m_scratch = wd;
        4'd2: m_cycle   = wd;
        4'd3: cnt_n     = wd;
        4'd4: m_reload  = wd;
        4'd5: {m_ie, m_auto, en_n} = wd[2:0];
        default: ;
      endcase
    end
    m_cnt = cnt_n;
    m_en  = en_n;
  endtask

  task automatic check_model();
    check("rd_line", bus.sys_r_line, bus.sys_r ? m_read(bus.sys_r_addr) : 32'h0);
    check("irq", 32'(irq), 32'(m_exp & m_ie));
    check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() > 0));
    check("tx_data", 32'(bus.tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  task automatic apply(input bit r, input logic [31:0] ra, input bit w,
                       input logic [31:0] wa, input logic [31:0] wd);
    bus.sys_r      = r;
    bus.sys_r_addr = ra;
    bus.sys_w      = w;
    bus.sys_w_addr = wa;
    bus.sys_w_line = wd;
    bus.tx_ready   = ready_v;
    #2;
    check_model();
  endtask

  task automatic tick();
    bit          rr, w, rdy;
    logic [31:0] wa, wd;
    rr = rst; w = bus.sys_w; wa = bus.sys_w_addr; wd = bus.sys_w_line; rdy = bus.tx_ready;
    @(posedge clk);
    m_step(rr, w, wa, wd, rdy);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    apply(1'b0, 32'h0, 1'b1, BASE + 32'(off), d);
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    apply(1'b1, BASE + 32'(off), 1'b0, 32'h0, 32'h0);
    check(name, bus.sys_r_line, exp);
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle();
    rst = 1'b1;
  endtask

  task automatic poll_irq(input string name, input int exp_k);
    int k;
    k = 0;
    while (k < 20) begin
      apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (irq) break;
      tick();
      k++;
    end
    check(name, 32'(k), 32'(exp_k));
  endtask

  task automatic drain_chk(input string name, input logic [7:0] exp_b);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check({name, "_valid"}, 32'(bus.tx_valid), 32'h1);
    check({name, "_data"}, 32'(bus.tx_data), 32'(exp_b));
    tick();
  endtask

  initial begin
    logic [7:0] exp_bytes[8];
    tbl[0] = '{1'b1, BASE + 32'd0,  32'hC0DE_0032};
    tbl[1] = '{1'b1, BASE + 32'd9,  32'hAAAA_AAAA};
    tbl[2] = '{1'b1, BASE + 32'd16, 32'hAAAA_AAAA};
    tbl[3] = '{1'b0, BASE + 32'd0,  32'h0};
    tbl[4] = '{1'b1, BASE + 32'd7,  32'h0};
    tbl[5] = '{1'b1, BASE + 32'd8,  32'h200};
    tbl[6] = '{1'b1, BASE + 32'd6,  32'h0};
    tbl[7] = '{1'b1, BASE + 32'd15, 32'hAAAA_AAAA};
    tbl[8] = '{1'b1, BASE - 32'd1,  32'hAAAA_AAAA};
    tbl[9] = '{1'b1, BASE + 32'd5,  32'h0};

    bus.sys_r = 0; bus.sys_r_addr = 0; bus.sys_w = 0; bus.sys_w_addr = 0;
    bus.sys_w_line = 0; bus.tx_ready = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].addr, 1'b0, 32'h0, 32'h0);
      check($sformatf("tbl%0d", i), bus.sys_r_line, tbl[i].exp);
      tick();
    end

    reset_dut();
    for (int i = 0; i < 5; i++) rd_chk("cycle_count", 4'd2, 32'(i));
    wr(4'd1, 32'h1234_5678);
    rd_chk("scratch", 4'd1, 32'h1234_5678);
    wr(4'd2, 32'hFFFF_FFFE);
    rd_chk("cycle_load", 4'd2, 32'hFFFF_FFFE);
    rd_chk("cycle_max", 4'd2, 32'hFFFF_FFFF);
    rd_chk("cycle_wrap", 4'd2, 32'h0);

    wr(4'd4, 32'd3);
    wr(4'd3, 32'd3);
    wr(4'd5, 32'd7);
    poll_irq("tmr_first", 4);
    wr(4'd6, 32'd1);
    poll_irq("tmr_period", 3);
    repeat (3) idle();
    wr(4'd6, 32'd1);
    rd_chk("exp_set_wins", 4'd6, 32'h1);
    wr(4'd5, 32'd0);
    wr(4'd6, 32'd1);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);
    tick();

    wr(4'd3, 32'd2);
    wr(4'd5, 32'd5);
    poll_irq("oneshot", 3);
    rd_chk("oneshot_en", 4'd5, 32'h4);
    repeat (3) idle();
    rd_chk("oneshot_cnt", 4'd3, 32'h0);
    wr(4'd6, 32'd1);
    wr(4'd5, 32'd0);

    ready_v = 1'b0;
    for (int i = 0; i < 9; i++) wr(4'd7, 32'h41 + 32'(i));
    rd_chk("fifo_full_stat", 4'd8, 32'h508);
    ready_v = 1'b1;
    for (int i = 0; i < 8; i++) drain_chk("drain", 8'h41 + 8'(i));
    apply(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("drained_valid", 32'(bus.tx_valid), 32'h0);
    tick();
    rd_chk("fifo_empty_stat", 4'd8, 32'h600);
    wr(4'd8, 32'h400);
    rd_chk("ovf_clear", 4'd8, 32'h200);

    ready_v = 1'b0;
    for (int i = 0; i < 8; i++) wr(4'd7, 32'h50 + 32'(i));
    ready_v = 1'b1;
    wr(4'd7, 32'h5A);
    ready_v = 1'b0;
    rd_chk("push_pop_full", 4'd8, 32'h108);
    ready_v = 1'b1;
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h51 + 8'(i);
    exp_bytes[7] = 8'h5A;
    for (int i = 0; i < 8; i++) drain_chk("pp_drain", exp_bytes[i]);

    for (int i = 0; i < 600; i++) begin
      bit          r, w;
      logic [3:0]  roff, woff;
      logic [31:0] ra, wa, wd;
      r    = 1'($urandom_range(0, 1));
      w    = ($urandom_range(0, 2) == 0);
      roff = 4'($urandom_range(0, 15));
      woff = 4'($urandom_range(0, 8));
      ra   = ($urandom_range(0, 15) == 0) ? 32'($urandom) : BASE + 32'(roff);
      wa   = ($urandom_range(0, 15) == 0) ? 32'($urandom) : BASE + 32'(woff);
      wd   = 32'($urandom);
      if (woff == 4'd3 || woff == 4'd4) wd = 32'($urandom_range(0, 6));
      ready_v = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 199) != 0);
      apply(r, ra, w, wa, wd);
      tick();
    end
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
